// File: rtl/tff_seq_ctrl.sv
// Command-driven sequencer for a bank of T flip-flops.
// Clears, toggles under mask, or steps the bank up/down N times.
module tff_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             hold,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] lo;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_t = '0;
    dn_t = '0;
    lo   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lo      = (WIDTH'(1) << i) - WIDTH'(1);
      up_t[i] = ((q & lo) == lo);
      dn_t[i] = ((q & lo) == '0);
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    t_vec     = '0;
    wrap_nxt  = 1'b0;
    cmd_ready = (state == IDLE) && !clr;
    busy      = (state == APPLY) || (state == RUN);
    done      = (state == DONE);
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (!cmd_op[1]) begin
            state_nxt = APPLY;
          end else if (cmd_arg == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            rem_nxt   = cmd_arg;
          end
        end
      end
      APPLY: begin
        t_vec     = (op_r == OP_CLEAR) ? q : mask_r;
        state_nxt = DONE;
      end
      RUN: begin
        if (!hold) begin
          t_vec    = op_r[0] ? dn_t : up_t;
          rem_nxt  = rem - CNT_W'(1);
          wrap_nxt = op_r[0] ? (q == '0) : (q == '1);
          if (rem == CNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      q      <= '0;
      rem    <= '0;
      wrap   <= 1'b0;
      op_r   <= OP_CLEAR;
      mask_r <= '0;
    end else begin
      state <= state_nxt;
      q     <= q ^ t_vec;
      rem   <= rem_nxt;
      wrap  <= wrap_nxt;
      if (cmd_valid && cmd_ready) begin
        op_r   <= cmd_op;
        mask_r <= cmd_mask;
      end
    end
  end

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Directed bench for tff_seq_ctrl.
// Outputs are sampled on the falling edge.
module tb_tff_seq_ctrl;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_TOG = 2'b01;
  localparam logic [1:0] OP_UP  = 2'b10;
  localparam logic [1:0] OP_DN  = 2'b11;

  logic       clk;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [7:0] cmd_arg;
  logic       hold;
  logic [3:0] q;
  logic [3:0] t_vec;
  logic       busy;
  logic       done;
  logic       wrap;

  int tests;
  int fails;

  tff_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_mask (cmd_mask),
    .cmd_arg  (cmd_arg),
    .hold     (hold),
    .q        (q),
    .t_vec    (t_vec),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  // Issue a command from IDLE; returns at the falling edge after acceptance.
  task automatic go(input logic [1:0] op, input logic [3:0] m,
                    input logic [7:0] a);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = m;
    cmd_arg   = a;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    clr       = 1'b1;
    hold      = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_TOG;
    cmd_mask  = 4'b1111;
    cmd_arg   = 8'd0;
    repeat (2) @(negedge clk);
    tests++;
    if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 ||
        wrap !== 1'b0 || cmd_ready !== 1'b0 || t_vec !== 4'b0000) begin
      fails++;
      $display("FAIL reset: q=%b busy=%b done=%b wrap=%b rdy=%b t=%b req 0000/0/0/0/0/0000",
               q, busy, done, wrap, cmd_ready, t_vec);
    end
    cmd_valid = 1'b0;
    clr       = 1'b0;
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: rdy=%b req 1", cmd_ready);
    end
    @(negedge clk);
    tests++;
    if (q !== 4'b0000 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: q=%b rdy=%b req 0000/1", q, cmd_ready);
    end
  endtask

  task automatic test_toggle;
    go(OP_TOG, 4'b1010, 8'd0);
    tests++;
    if (busy !== 1'b1 || q !== 4'b0000 || t_vec !== 4'b1010 || done !== 1'b0) begin
      fails++;
      $display("FAIL tog1_apply: busy=%b q=%b t=%b done=%b req 1/0000/1010/0",
               busy, q, t_vec, done);
    end
    @(negedge clk);
    tests++;
    if (q !== 4'b1010 || done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL tog1_done: q=%b done=%b busy=%b rdy=%b req 1010/1/0/0",
               q, done, busy, cmd_ready);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL tog1_idle: done=%b rdy=%b wrap=%b req 0/1/0", done, cmd_ready, wrap);
    end
    go(OP_TOG, 4'b0011, 8'd0);
    @(negedge clk);
    tests++;
    if (q !== 4'b1001 || done !== 1'b1) begin
      fails++;
      $display("FAIL tog2: q=%b done=%b req 1001/1", q, done);
    end
    @(negedge clk);
    go(OP_CLR, 4'b0110, 8'd0);
    tests++;
    if (t_vec !== 4'b1001) begin
      fails++;
      $display("FAIL clear_tvec: t=%b req 1001", t_vec);
    end
    @(negedge clk);
    tests++;
    if (q !== 4'b0000 || done !== 1'b1 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL clear: q=%b done=%b wrap=%b req 0000/1/0", q, done, wrap);
    end
    @(negedge clk);
  endtask

  task automatic test_count_up;
    logic [3:0] eq [7] = '{4'b1101, 4'b1110, 4'b1111, 4'b0000,
                           4'b0001, 4'b0010, 4'b0010};
    logic [6:0] ew = 7'b0001000;
    logic [6:0] ed = 7'b0100000;
    int nb = 0;
    int nd = 0;
    go(OP_TOG, 4'b1101, 8'd0);
    repeat (2) @(negedge clk);
    go(OP_UP, 4'b0000, 8'd5);
    for (int j = 0; j < 7; j++) begin
      if (j > 0) @(negedge clk);
      tests++;
      if (q !== eq[j] || wrap !== ew[j] || done !== ed[j]) begin
        fails++;
        $display("FAIL up5 step%0d: q=%b wrap=%b done=%b req %b/%b/%b",
                 j, q, wrap, done, eq[j], ew[j], ed[j]);
      end
      if (busy) nb++;
      if (done) nd++;
    end
    tests++;
    if (nb != 5 || nd != 1) begin
      fails++;
      $display("FAIL up5_counts: busy=%0d done=%0d req 5/1", nb, nd);
    end
  endtask

  task automatic test_count_down;
    logic [3:0] eq [5] = '{4'b0001, 4'b0000, 4'b1111, 4'b1110, 4'b1110};
    logic [3:0] et [5] = '{4'b0001, 4'b1111, 4'b0001, 4'b0000, 4'b0000};
    logic [4:0] ew = 5'b00100;
    logic [4:0] ed = 5'b01000;
    go(OP_TOG, 4'b0011, 8'd0);
    repeat (2) @(negedge clk);
    go(OP_DN, 4'b0000, 8'd3);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      tests++;
      if (q !== eq[j] || t_vec !== et[j] || wrap !== ew[j] || done !== ed[j]) begin
        fails++;
        $display("FAIL dn3 step%0d: q=%b t=%b wrap=%b done=%b req %b/%b/%b/%b",
                 j, q, t_vec, wrap, done, eq[j], et[j], ew[j], ed[j]);
      end
    end
  endtask

  task automatic test_hold;
    go(OP_CLR, 4'b0000, 8'd0);
    repeat (2) @(negedge clk);
    go(OP_UP, 4'b0000, 8'd4);
    repeat (2) @(negedge clk);
    tests++;
    if (q !== 4'b0010) begin
      fails++;
      $display("FAIL hold_pre: q=%b req 0010", q);
    end
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      tests++;
      if (q !== 4'b0010 || t_vec !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL hold%0d: q=%b t=%b busy=%b done=%b req 0010/0000/1/0",
                 h, q, t_vec, busy, done);
      end
    end
    hold = 1'b0;
    @(negedge clk);
    tests++;
    if (q !== 4'b0011 || done !== 1'b0) begin
      fails++;
      $display("FAIL hold_resume: q=%b done=%b req 0011/0", q, done);
    end
    @(negedge clk);
    tests++;
    if (q !== 4'b0100 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_done: q=%b done=%b busy=%b req 0100/1/0", q, done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_arg;
    go(OP_UP, 4'b1111, 8'd0);
    tests++;
    if (q !== 4'b0100 || done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL zero_arg: q=%b done=%b busy=%b rdy=%b req 0100/1/0/0",
               q, done, busy, cmd_ready);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || q !== 4'b0100) begin
      fails++;
      $display("FAIL zero_arg_idle: done=%b rdy=%b q=%b req 0/1/0100", done, cmd_ready, q);
    end
  endtask

  task automatic test_back_to_back;
    cmd_valid = 1'b1;
    cmd_op    = OP_UP;
    cmd_mask  = 4'b0000;
    cmd_arg   = 8'd0;
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done: done=%b rdy=%b req 1/0", done, cmd_ready);
    end
    cmd_op   = OP_TOG;
    cmd_mask = 4'b1000;
    @(negedge clk);
    tests++;
    if (q !== 4'b0100 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: q=%b busy=%b rdy=%b done=%b req 0100/0/1/0",
               q, busy, cmd_ready, done);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_mask  = 4'b0001;
    #1;
    tests++;
    if (busy !== 1'b1 || t_vec !== 4'b1000) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b t=%b req 1/1000", busy, t_vec);
    end
    @(negedge clk);
    tests++;
    if (q !== 4'b1100 || done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_result: q=%b done=%b req 1100/1", q, done);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int nd = 0;
    go(OP_UP, 4'b0000, 8'd10);
    repeat (2) @(negedge clk);
    tests++;
    if (q !== 4'b1110 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: q=%b busy=%b req 1110/1", q, busy);
    end
    #2 clr = 1'b1;
    #1;
    tests++;
    if (q !== 4'b0000 || busy !== 1'b0 || cmd_ready !== 1'b0 ||
        done !== 1'b0 || t_vec !== 4'b0000 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL abort_clr: q=%b busy=%b rdy=%b done=%b t=%b wrap=%b req 0000/0/0/0/0000/0",
               q, busy, cmd_ready, done, t_vec, wrap);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    tests++;
    if (cmd_ready !== 1'b1 || q !== 4'b0000) begin
      fails++;
      $display("FAIL abort_release: rdy=%b q=%b req 1/0000", cmd_ready, q);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (done) nd++;
    end
    tests++;
    if (nd != 0 || q !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_after: dones=%0d q=%b busy=%b req 0/0000/0", nd, q, busy);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_toggle();
    test_count_up();
    test_count_down();
    test_hold();
    test_zero_arg();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
